// File: rtl/clock_mode_if.sv
// clock_mode_if: CLKSET request, MMCM lock and switched clock-select bundle.
interface clock_mode_if;
  logic [6:0] cfg_in;
  logic       cfg_wr;
  logic       locked;
  logic [6:0] cfg_out;
  logic [4:0] sel;
  logic [2:0] tap;
  logic       busy;
  logic       lock_err;
  modport master (output cfg_in, cfg_wr, locked, input cfg_out, sel, tap, busy, lock_err);
  modport slave (input cfg_in, cfg_wr, locked, output cfg_out, sel, tap, busy, lock_err);
endinterface

// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: sequences CLKSET writes through MMCM lock and settle, then swaps
// the BUFGMUX selects and the effective config in one registered step.
module clock_mode_ctrl #(
  parameter int SETTLE_CYCLES = 16000,
  parameter int LOCK_TIMEOUT  = 1600000,
  parameter int SWITCH_CYCLES = 8,
  parameter int CNT_W         = 24
) (
  input  logic clock_160,
  input  logic nres,
  clock_mode_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_LOCK, SETTLE, SWITCH} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0] cin_q, tgt_q, tgt_d, pend_q, pend_d, cfg_q, cfg_d, req;
  logic wr_q, pv_q, pv_d, err_q, err_d, busy_q, apply;
  logic [2:0] tap_q, tap_d;
  logic [4:0] sel_q, sel_d;

  function automatic logic [2:0] decode(input logic [6:0] c);
    logic [4:0] k = {c[6:5], c[2:0]};
    return k == 5'b11111 ? 3'd5 : k == 5'b11110 ? 3'd4 : k == 5'b11101 ? 3'd3 :
           (k == 5'b11100 || k[2:0] == 3'b000) ? 3'd2 :
           (k == 5'b11011 || k == 5'b01010) ? 3'd1 : 3'd0;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - CNT_W'(1);
    tgt_d   = tgt_q;
    err_d   = err_q;
    apply   = 1'b0;
    pend_d  = (wr_q && state_q != IDLE) ? cin_q : pend_q;
    pv_d    = pv_q | (wr_q && state_q != IDLE);
    req     = wr_q ? cin_q : pend_q;
    case (state_q)
      IDLE: begin
        pv_d = 1'b0;
        if ((wr_q || pv_q) && req != cfg_q) begin
          tgt_d   = req;
          state_d = WAIT_LOCK;
          cnt_d   = CNT_W'(LOCK_TIMEOUT - 1);
        end
      end
      WAIT_LOCK:
        if (bus.locked) begin
          if ((tgt_q[6] & ~cfg_q[6]) | (tgt_q[5] & ~cfg_q[5])) begin
            state_d = SETTLE;
            cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
          end else apply = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
          err_d   = 1'b1;
          pv_d    = 1'b0;
        end
      SETTLE:
        if (!bus.locked) begin
          state_d = WAIT_LOCK;
          cnt_d   = CNT_W'(LOCK_TIMEOUT - 1);
        end else if (cnt_q == '0) apply = 1'b1;
      default: if (cnt_q == '0) state_d = IDLE;
    endcase
    if (apply) begin
      state_d = SWITCH;
      cnt_d   = CNT_W'(SWITCH_CYCLES - 1);
    end
    cfg_d = apply ? tgt_q : cfg_q;
    tap_d = apply ? decode(tgt_q) : tap_q;
    sel_d = tap_d == 3'd0 ? 5'd0 : 5'd1 << (tap_d - 3'd1);
  end

  always_ff @(posedge clock_160 or negedge nres)
    if (!nres) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cin_q   <= '0;
      wr_q    <= 1'b0;
      tgt_q   <= '0;
      pend_q  <= '0;
      pv_q    <= 1'b0;
      cfg_q   <= '0;
      tap_q   <= 3'd2;
      sel_q   <= 5'b00010;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cin_q   <= bus.cfg_in;
      wr_q    <= bus.cfg_wr;
      tgt_q   <= tgt_d;
      pend_q  <= pend_d;
      pv_q    <= pv_d;
      cfg_q   <= cfg_d;
      tap_q   <= tap_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      busy_q  <= state_d != IDLE;
    end

  assign bus.cfg_out  = cfg_q;
  assign bus.tap      = tap_q;
  assign bus.sel      = sel_q;
  assign bus.busy     = busy_q;
  assign bus.lock_err = err_q;
endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb_clock_mode_ctrl: randomized CLKSET traffic; a timeline model predicts every
// output change, and a negedge monitor pops and compares each one as it appears.
module tb_clock_mode_ctrl;
  localparam int S = 40, T = 60, W = 8;
  logic clk = 1'b0, nres = 1'b0;
  always #5 clk = ~clk;

  clock_mode_if bus();
  clock_mode_ctrl #(.SETTLE_CYCLES(S), .LOCK_TIMEOUT(T), .SWITCH_CYCLES(W), .CNT_W(8))
    dut (.clock_160(clk), .nres(nres), .bus(bus));

  typedef struct packed {
    logic [31:0] cyc;
    logic [6:0]  cfg;
    logic [2:0]  tap;
    logic [4:0]  sel;
    logic        busy;
    logic        err;
  } ev_t;

  ev_t q[$];
  int compared = 0, mismatched = 0, cyc = 0;
  bit mon_en = 0;
  logic [6:0] mcfg = '0;
  logic merr = 1'b0;
  logic [16:0] prev = '0;

  always @(posedge clk) cyc++;

  function automatic logic [2:0] tap_ref(input logic [6:0] c);
    logic both = c[6] & c[5];
    int cs = int'(c[2:0]);
    if (both && cs >= 4) return 3'(cs - 2);
    if (cs == 0) return 3'd2;
    if ((both && cs == 3) || (!c[6] && c[5] && cs == 2)) return 3'd1;
    return 3'd0;
  endfunction

  function automatic ev_t mk(input int c, input logic [6:0] f, input logic b, input logic e);
    ev_t r;
    r.cyc  = 32'(c);
    r.cfg  = f;
    r.tap  = tap_ref(f);
    r.sel  = r.tap == 0 ? 5'd0 : 5'(1 << (int'(r.tap) - 1));
    r.busy = b;
    r.err  = e;
    return r;
  endfunction

  function automatic bit settle(input logic [6:0] nw, input logic [6:0] cur);
    return (nw[6] && !cur[6]) || (nw[5] && !cur[5]);
  endfunction

  function automatic logic [6:0] rnd_cfg();
    logic [31:0] r = $urandom;
    return r[0] ? {2'b11, r[5:4], r[8:6]} : r[7:1];
  endfunction

  always @(negedge clk) begin
    ev_t o, e;
    logic [16:0] cur;
    cur = {bus.cfg_out, bus.tap, bus.sel, bus.busy, bus.lock_err};
    if (mon_en && cur != prev) begin
      o = {32'(cyc), cur};
      compared++;
      if (q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_change cyc=%0d got cfg=%b tap=%0d sel=%b busy=%b err=%b, required no change",
                 cyc, o.cfg, o.tap, o.sel, o.busy, o.err);
      end else begin
        e = q.pop_front();
        if (o != e) begin
          mismatched++;
          $display("FAIL event got cyc=%0d cfg=%b tap=%0d sel=%b busy=%b err=%b, required cyc=%0d cfg=%b tap=%0d sel=%b busy=%b err=%b",
                   o.cyc, o.cfg, o.tap, o.sel, o.busy, o.err, e.cyc, e.cfg, e.tap, e.sel, e.busy, e.err);
        end
      end
    end
    prev = cur;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s got=%0h required=%0h", nm, got, exp);
    end
  endtask

  task automatic wait_quiet();
    int n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL timeout outstanding=%0d required 0", q.size());
      q.delete();
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic issue(input logic [6:0] v, output int n);
    @(negedge clk);
    bus.cfg_in = v;
    bus.cfg_wr = 1'b1;
    n = cyc + 1;
    @(negedge clk);
    bus.cfg_wr = 1'b0;
  endtask

  task automatic do_write(input logic [6:0] v);
    int n, sw;
    issue(v, n);
    if (v != mcfg) begin
      sw = n + 2 + (settle(v, mcfg) ? S : 0);
      q.push_back(mk(n + 1, mcfg, 1, merr));
      q.push_back(mk(sw, v, 1, merr));
      q.push_back(mk(sw + W, v, 0, merr));
      mcfg = v;
    end
    wait_quiet();
  endtask

  task automatic lock_to(input logic [6:0] v);
    int n;
    bus.locked = 1'b0;
    issue(v, n);
    q.push_back(mk(n + 1, mcfg, 1, merr));
    merr = 1'b1;
    q.push_back(mk(n + 1 + T, mcfg, 0, 1));
    wait_quiet();
    bus.locked = 1'b1;
  endtask

  task automatic relock(input logic [6:0] v);
    int n, d, sw;
    issue(v, n);
    d = n + 2 + $urandom_range(1, S - 2);
    sw = d + 5 + S;
    q.push_back(mk(n + 1, mcfg, 1, merr));
    q.push_back(mk(sw, v, 1, merr));
    q.push_back(mk(sw + W, v, 0, merr));
    mcfg = v;
    while (cyc + 1 < d) @(negedge clk);
    bus.locked = 1'b0;
    repeat (5) @(negedge clk);
    bus.locked = 1'b1;
    wait_quiet();
  endtask

  task automatic pend3(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c);
    int n, nb, nc, swa, x, swc;
    issue(a, n);
    swa = n + 2 + (settle(a, mcfg) ? S : 0);
    x = swa + W;
    q.push_back(mk(n + 1, mcfg, 1, merr));
    q.push_back(mk(swa, a, 1, merr));
    q.push_back(mk(x, a, 0, merr));
    mcfg = a;
    if (c != a) begin
      swc = x + 2 + (settle(c, a) ? S : 0);
      q.push_back(mk(x + 1, a, 1, merr));
      q.push_back(mk(swc, c, 1, merr));
      q.push_back(mk(swc + W, c, 0, merr));
      mcfg = c;
    end
    issue(b, nb);
    issue(c, nc);
    wait_quiet();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d required finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] v, b, c;
    int n, sw;
    bus.cfg_in = '0;
    bus.cfg_wr = 1'b0;
    bus.locked = 1'b1;
    repeat (3) @(negedge clk);
    nres = 1'b1;
    @(negedge clk);
    chk("reset_cfg", 32'(bus.cfg_out), 0);
    chk("reset_tap", 32'(bus.tap), 2);
    chk("reset_sel", 32'(bus.sel), 32'b00010);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_err", 32'(bus.lock_err), 0);
    mon_en = 1;
    do_write(7'b1100000);
    do_write(7'b1100111);
    do_write(7'b1101111);
    for (int i = 0; i < 12; i++) do_write(rnd_cfg());
    do_write(mcfg);
    do v = rnd_cfg(); while (v == mcfg);
    lock_to(v);
    do_write(7'b1010010);
    v = rnd_cfg();
    v[6] = 1'b0;
    do_write(v);
    v = rnd_cfg();
    v[6] = 1'b1;
    relock(v);
    for (int i = 0; i < 3; i++) begin
      do v = rnd_cfg(); while (v == mcfg);
      b = rnd_cfg();
      c = rnd_cfg();
      pend3(v, b, c);
    end
    do v = rnd_cfg(); while (v == mcfg || settle(v, mcfg));
    issue(v, n);
    sw = n + 2;
    q.push_back(mk(n + 1, mcfg, 1, merr));
    q.push_back(mk(sw, v, 1, merr));
    q.push_back(mk(sw + 4, 7'd0, 0, 0));
    mcfg = '0;
    merr = 1'b0;
    while (cyc < sw + 3) @(negedge clk);
    #1 nres = 1'b0;
    repeat (2) @(negedge clk);
    nres = 1'b1;
    wait_quiet();
    do_write(rnd_cfg());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/clock_mode_ctrl.md
# clock_mode_ctrl

Sequencer for the Propeller clock-mode switch. It accepts CLKSET writes of the 7-bit clock configuration (PLLENA, OSCENA, OSCM1, OSCM0, CLKSEL[2:0]) and waits for MMCM lock and oscillator/PLL settle time. It then changes the BUFGMUX_CTRL select vector of the cog-clock mux chain and the effective config register together, in one step. It sits between the hub CLKSET path and the clock generator, runs on the free-running 160 MHz clock, and replaces direct latching of `cfg`.

## Interface
- `SETTLE_CYCLES`, 16000: settle delay (100 us at 160 MHz), applied when a write newly enables PLL or oscillator.
- `LOCK_TIMEOUT`, 1600000: maximum number of cycles spent waiting for `locked`.
- `SWITCH_CYCLES`, 8: cycles `busy` is held after the selects change, so the BUFGMUX handover completes.
- `CNT_W`, 24: width of the shared down-counter. Must hold max(SETTLE_CYCLES, LOCK_TIMEOUT, SWITCH_CYCLES).

- `clock_160`  in  1  free-running 160 MHz clock; all logic is on its rising edge.
- `nres`  in  1  asynchronous active-low reset.
- `cfg_in`  in  7  requested config: [6] PLLENA, [5] OSCENA, [4:3] OSCM, [2:0] CLKSEL.
- `cfg_wr`  in  1  single-cycle write strobe for `cfg_in`.
- `locked`  in  1  MMCM LOCKED, already synchronous to `clock_160`.
- `cfg_out`  out  7  effective config, driven to the generator as `cfg`.
- `sel`  out  5  mux selects {X16, X8, X4, X2, X1}; at most one bit set; all zero selects RCSLOW.
- `tap`  out  3  current tap: 0 RCSLOW, 1 X1, 2 X2/RCFAST, 3 X4, 4 X8, 5 X16.
- `busy`  out  1  high while a switch is in progress.
- `lock_err`  out  1  sticky lock-timeout flag.

## Operation
- Tap decode, with k = {cfg[6:5], cfg[2:0]}, in priority order:
  - 11111 -> X16
  - 11110 -> X8
  - 11101 -> X4
  - 11100 or k[2:0]==000 -> X2
  - 11011 or 01010 -> X1
  - otherwise -> RCSLOW
- `sel` is the one-hot of the decoded tap; RCSLOW gives 00000.
- Reset values: `cfg_out`=0, `tap`=2, `sel`=00010, `busy`=0, `lock_err`=0. The FSM resets to IDLE with no pending request.
- States: IDLE, WAIT_LOCK, SETTLE, SWITCH.
- IDLE:
  - `cfg_wr` with `cfg_in`!=`cfg_out` latches the target and moves to WAIT_LOCK.
  - `cfg_in`==`cfg_out` is a no-op; `busy` stays 0.
- WAIT_LOCK:
  - Counter loads LOCK_TIMEOUT on entry.
  - If `locked`=1, go to SETTLE when settle is needed, else go directly to SWITCH.
  - Settle is needed when (tgt[6]&~cfg_out[6]) | (tgt[5]&~cfg_out[5]).
  - If the counter expires while `locked`=0: set `lock_err`, discard target and pending, return to IDLE. Outputs are unchanged.
- SETTLE:
  - Counter loads SETTLE_CYCLES on entry and goes to SWITCH at zero.
  - If `locked` falls, go back to WAIT_LOCK; both timeout and settle restart.
- SWITCH:
  - On the entry edge, `cfg_out`, `tap` and `sel` update together from the target.
  - Hold SWITCH_CYCLES cycles, then go to IDLE. `locked` is ignored here.
- Pending request:
  - `cfg_wr` while `busy` stores `cfg_in` in a one-deep pending register; the last write wins.
  - In IDLE, a valid pending request is treated as a `cfg_wr` of that value, and pending is cleared.
  - `cfg_wr` in the same IDLE cycle as a valid pending request: `cfg_wr` wins and pending is cleared.
- `lock_err` clears only on reset.
- `nres` low at any point forces reset values immediately, including mid-switch.

## Timing
- `cfg_wr` sampled at edge N:
  - `busy`=1 from N+1.
  - With `locked`=1 and no settle: `sel`/`cfg_out` change at edge N+2; `busy` falls at N+2+SWITCH_CYCLES.
  - With settle: `sel`/`cfg_out` change at edge N+2+SETTLE_CYCLES.
- Pending request: IDLE lasts exactly one cycle before WAIT_LOCK.
- Lock timeout: `lock_err` rises at edge N+1+LOCK_TIMEOUT; `busy` falls on the same edge.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Reset with `nres`=0, then release -> `sel`=00010, `tap`=2, `cfg_out`=0, `busy`=0.
- `locked`=1, `cfg_out`=7'b1100000, write 7'b1100111 (no new enable) -> `sel`=10000 and `tap`=5 at N+2; `busy` falls at N+10.
- From reset, write 7'b1101111 -> `cfg_out` updates at N+2+16000; `lock_err` stays 0.
- Hold `locked`=0, write 7'b1100110 -> `lock_err`=1 at N+1+1600000; `cfg_out` stays 0; `busy`=0.
- Drop `locked` for 5 cycles mid-SETTLE -> settle restarts from the re-lock cycle; `sel` updates 16000 cycles after re-lock.
- Three writes A, B, C while busy -> switch goes to A, then C; B is never applied; write of the current `cfg_out` value -> `busy` never rises.
